// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with a parametrised width and depth,
// a fill-level count, almost-full/almost-empty flags and registered
// overflow/underflow pulses.
// Optional build macro SYNC_FIFO_FWFT_EN: first-word-fall-through read port.
// When it is undefined, rdata is registered and loads on each accepted read.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT  = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // Flags are decodes of the count register only, so no request input
    // reaches an output combinationally.
    assign full         = (count_q == CNT_MAX);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is allowed only when a read frees a slot on
    // the same edge; a full FIFO is never empty, so that read is accepted.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    // Next-state for the pointers, the fill level and the error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en && full && !rd_en;
        underflow_d = rd_en && empty;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state register; reset wins over any same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; forced to zero when nothing is stored.
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem_q[rd_ptr_q];
        end
    end
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read port: loads the head word on an accepted read, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem_q[rd_ptr_q];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_WIDTH=8, DEPTH=6, AF=5, AE=1).
// Expected rdata is tabulated for both the registered and the FWFT read port.
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] wdata, rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, wr;
        logic [7:0] wd;
        logic       rd;
        logic [2:0] cnt;
        logic       full, empty, af, ae, ovf, unf;
        logic [7:0] rd_std, rd_fw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic rd,
                                logic [2:0] c, logic f, logic e, logic af,
                                logic ae, logic o, logic u,
                                logic [7:0] rs, logic [7:0] rf);
        vec_t v;
        v.rst = r; v.wr = w; v.wd = d; v.rd = rd; v.cnt = c; v.full = f;
        v.empty = e; v.af = af; v.ae = ae; v.ovf = o; v.unf = u;
        v.rd_std = rs; v.rd_fw = rf;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic w, logic [7:0] d, logic rd);
        @(negedge clk);
        rst = r; wr_en = w; wdata = d; rd_en = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(int idx, vec_t v);
        chk("count", idx, {5'b0, count}, {5'b0, v.cnt});
        chk("full", idx, {7'b0, full}, {7'b0, v.full});
        chk("empty", idx, {7'b0, empty}, {7'b0, v.empty});
        chk("almost_full", idx, {7'b0, almost_full}, {7'b0, v.af});
        chk("almost_empty", idx, {7'b0, almost_empty}, {7'b0, v.ae});
        chk("overflow", idx, {7'b0, overflow}, {7'b0, v.ovf});
        chk("underflow", idx, {7'b0, underflow}, {7'b0, v.unf});
        chk("rdata", idx, rdata, FWFT ? v.rd_fw : v.rd_std);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wdata = 8'h00; rd_en = 1'b0;

        // reset held during writes
        vecs.push_back(mk(1,1,8'hAA,0, 0,0,1,0,1,0,0, 8'h00,8'h00));
        vecs.push_back(mk(1,1,8'hAB,0, 0,0,1,0,1,0,0, 8'h00,8'h00));
        // fill to full
        vecs.push_back(mk(0,1,8'h11,0, 1,0,0,0,1,0,0, 8'h00,8'h11));
        vecs.push_back(mk(0,1,8'h12,0, 2,0,0,0,0,0,0, 8'h00,8'h11));
        vecs.push_back(mk(0,1,8'h13,0, 3,0,0,0,0,0,0, 8'h00,8'h11));
        vecs.push_back(mk(0,1,8'h14,0, 4,0,0,0,0,0,0, 8'h00,8'h11));
        vecs.push_back(mk(0,1,8'h15,0, 5,0,0,1,0,0,0, 8'h00,8'h11));
        vecs.push_back(mk(0,1,8'h16,0, 6,1,0,1,0,0,0, 8'h00,8'h11));
        // back-to-back overflow, then pulse clears
        vecs.push_back(mk(0,1,8'hFF,0, 6,1,0,1,0,1,0, 8'h00,8'h11));
        vecs.push_back(mk(0,1,8'hFE,0, 6,1,0,1,0,1,0, 8'h00,8'h11));
        vecs.push_back(mk(0,0,8'h00,0, 6,1,0,1,0,0,0, 8'h00,8'h11));
        // drain
        vecs.push_back(mk(0,0,8'h00,1, 5,0,0,1,0,0,0, 8'h11,8'h12));
        vecs.push_back(mk(0,0,8'h00,1, 4,0,0,0,0,0,0, 8'h12,8'h13));
        vecs.push_back(mk(0,0,8'h00,1, 3,0,0,0,0,0,0, 8'h13,8'h14));
        vecs.push_back(mk(0,0,8'h00,1, 2,0,0,0,0,0,0, 8'h14,8'h15));
        vecs.push_back(mk(0,0,8'h00,1, 1,0,0,0,1,0,0, 8'h15,8'h16));
        vecs.push_back(mk(0,0,8'h00,1, 0,0,1,0,1,0,0, 8'h16,8'h00));
        // pointers past the wrap
        vecs.push_back(mk(0,1,8'h21,0, 1,0,0,0,1,0,0, 8'h16,8'h21));
        vecs.push_back(mk(0,1,8'h22,0, 2,0,0,0,0,0,0, 8'h16,8'h21));
        vecs.push_back(mk(0,1,8'h23,1, 2,0,0,0,0,0,0, 8'h21,8'h22));
        vecs.push_back(mk(0,0,8'h00,1, 1,0,0,0,1,0,0, 8'h22,8'h23));
        vecs.push_back(mk(0,0,8'h00,1, 0,0,1,0,1,0,0, 8'h23,8'h00));
        // two consecutive underflows
        vecs.push_back(mk(0,0,8'h00,1, 0,0,1,0,1,0,1, 8'h23,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 0,0,1,0,1,0,1, 8'h23,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,1,0,1,0,0, 8'h23,8'h00));
        // simultaneous read+write while empty
        vecs.push_back(mk(0,1,8'h5A,1, 1,0,0,0,1,0,1, 8'h23,8'h5A));
        vecs.push_back(mk(0,0,8'h00,1, 0,0,1,0,1,0,0, 8'h5A,8'h00));
        // refill across the wrap
        vecs.push_back(mk(0,1,8'h31,0, 1,0,0,0,1,0,0, 8'h5A,8'h31));
        vecs.push_back(mk(0,1,8'h32,0, 2,0,0,0,0,0,0, 8'h5A,8'h31));
        vecs.push_back(mk(0,1,8'h33,0, 3,0,0,0,0,0,0, 8'h5A,8'h31));
        vecs.push_back(mk(0,1,8'h34,0, 4,0,0,0,0,0,0, 8'h5A,8'h31));
        vecs.push_back(mk(0,1,8'h35,0, 5,0,0,1,0,0,0, 8'h5A,8'h31));
        vecs.push_back(mk(0,1,8'h36,0, 6,1,0,1,0,0,0, 8'h5A,8'h31));
        // simultaneous read+write while full
        vecs.push_back(mk(0,1,8'hA5,1, 6,1,0,1,0,0,0, 8'h31,8'h32));
        vecs.push_back(mk(0,0,8'h00,1, 5,0,0,1,0,0,0, 8'h32,8'h33));
        vecs.push_back(mk(0,0,8'h00,1, 4,0,0,0,0,0,0, 8'h33,8'h34));
        vecs.push_back(mk(0,0,8'h00,1, 3,0,0,0,0,0,0, 8'h34,8'h35));
        vecs.push_back(mk(0,0,8'h00,1, 2,0,0,0,0,0,0, 8'h35,8'h36));
        vecs.push_back(mk(0,0,8'h00,1, 1,0,0,0,1,0,0, 8'h36,8'hA5));
        vecs.push_back(mk(0,0,8'h00,1, 0,0,1,0,1,0,0, 8'hA5,8'h00));
        // reset mid-operation overrides requests
        vecs.push_back(mk(0,1,8'h77,0, 1,0,0,0,1,0,0, 8'hA5,8'h77));
        vecs.push_back(mk(1,1,8'h88,1, 0,0,1,0,1,0,0, 8'h00,8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd);
            check_all(i, vecs[i]);
        end

        // single word in, popped, then held across idle cycles
        drive(0, 1, 8'h3C, 0);
        chk("seq_count", 100, {5'b0, count}, 8'd1);
        chk("seq_empty", 100, {7'b0, empty}, 8'd0);
        chk("seq_rdata", 100, rdata, FWFT ? 8'h3C : 8'h00);
        drive(0, 0, 8'h00, 1);
        chk("seq_empty", 101, {7'b0, empty}, 8'd1);
        chk("seq_rdata", 101, rdata, FWFT ? 8'h00 : 8'h3C);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 8'h00, 0);
            chk("seq_hold", 102 + k, rdata, FWFT ? 8'h00 : 8'h3C);
            chk("seq_unf", 102 + k, {7'b0, underflow}, 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
